// File: rtl/bitonic_merger_pipe.sv
// Pipelined bitonic merge network: one registered half-cleaner level per stage, sorts a bitonic vector asc/desc.
// Latency $clog2(N) cycles, 1 vector/cycle; stalls whole pipe when dout is held. Option: BITONIC_MERGER_SWAP_CNT_EN.
module bitonic_merger_pipe #(
  parameter int WIDTH = 4,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] din,
  input  logic               in_desc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WIDTH-1:0] dout
`ifdef BITONIC_MERGER_SWAP_CNT_EN
  ,
  output logic [$clog2((N/2)*$clog2(N)+1)-1:0] swap_cnt
`endif
);

  localparam int STAGES = $clog2(N);
`ifdef BITONIC_MERGER_SWAP_CNT_EN
  localparam int CW = $clog2((N/2)*STAGES+1);
`endif

  logic [N*WIDTH-1:0] data_q [STAGES];
  logic               vld_q  [STAGES];
  logic               desc_q [STAGES];
`ifdef BITONIC_MERGER_SWAP_CNT_EN
  logic [CW-1:0]      cnt_q  [STAGES];
`endif

  // The whole pipe moves in lockstep, so ready never looks at in_valid.
  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  for (genvar s = 0; s < STAGES; s++) begin : g_lvl
    localparam int B = N >> s;
    localparam int H = B / 2;

    logic [N*WIDTH-1:0] lvl_in;
    logic [N*WIDTH-1:0] lvl_out;
    logic               lvl_vld;
    logic               lvl_desc;
    logic [N/2-1:0]     swp;

    if (s == 0) begin : g_head
      assign lvl_in   = din;
      assign lvl_vld  = in_valid & in_ready;
      assign lvl_desc = in_desc;
    end else begin : g_body
      assign lvl_in   = data_q[s-1];
      assign lvl_vld  = vld_q[s-1];
      assign lvl_desc = desc_q[s-1];
    end

    // Pair p maps to element lo inside block p/H, partner lo+H; every element is covered once.
    for (genvar p = 0; p < N/2; p++) begin : g_ce
      localparam int LO = (p / H) * B + (p % H);
      localparam int HI = LO + H;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      assign a      = lvl_in[LO*WIDTH +: WIDTH];
      assign b      = lvl_in[HI*WIDTH +: WIDTH];
      assign swp[p] = lvl_desc ? (a < b) : (a > b);
      assign lvl_out[LO*WIDTH +: WIDTH] = swp[p] ? b : a;
      assign lvl_out[HI*WIDTH +: WIDTH] = swp[p] ? a : b;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q[s] <= '0;
        vld_q[s]  <= 1'b0;
        desc_q[s] <= 1'b0;
      end else if (advance) begin
        data_q[s] <= lvl_out;
        vld_q[s]  <= lvl_vld;
        desc_q[s] <= lvl_desc;
      end
    end

`ifdef BITONIC_MERGER_SWAP_CNT_EN
    logic [CW-1:0] cnt_in;
    logic [CW-1:0] cnt_out;

    if (s == 0) begin : g_cnt_head
      assign cnt_in = '0;
    end else begin : g_cnt_body
      assign cnt_in = cnt_q[s-1];
    end

    always_comb begin
      cnt_out = cnt_in;
      for (int p = 0; p < N/2; p++) begin
        cnt_out = cnt_out + CW'(swp[p]);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q[s] <= '0;
      end else if (advance) begin
        cnt_q[s] <= cnt_out;
      end
    end
`endif
  end

  assign dout      = data_q[STAGES-1];
  assign out_valid = vld_q[STAGES-1];
`ifdef BITONIC_MERGER_SWAP_CNT_EN
  assign swap_cnt  = cnt_q[STAGES-1];
`endif

endmodule

// File: tb/tb_bitonic_merger_pipe.sv
// Bench for bitonic_merger_pipe: directed N=4 scenarios plus randomized N=8/N=16 streams
// scored against an array-based reference (plain sort for bitonic input, explicit network otherwise).
module tb_bitonic_merger_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         iv4, ir4, ds4, ov4, or4;
  logic [15:0]  din4, do4;
  logic         iv8, ir8, ds8, ov8, or8;
  logic [63:0]  din8, do8;
  logic         iv16, ir16, ds16, ov16, or16;
  logic [127:0] din16, do16;
`ifdef BITONIC_MERGER_SWAP_CNT_EN
  logic [2:0]   sc4;
  logic [3:0]   sc8;
  logic [5:0]   sc16;
`endif

  bitonic_merger_pipe #(.WIDTH(4), .N(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .din(din4), .in_desc(ds4),
    .out_valid(ov4), .out_ready(or4), .dout(do4)
`ifdef BITONIC_MERGER_SWAP_CNT_EN
    , .swap_cnt(sc4)
`endif
  );

  bitonic_merger_pipe #(.WIDTH(8), .N(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .din(din8), .in_desc(ds8),
    .out_valid(ov8), .out_ready(or8), .dout(do8)
`ifdef BITONIC_MERGER_SWAP_CNT_EN
    , .swap_cnt(sc8)
`endif
  );

  bitonic_merger_pipe #(.WIDTH(8), .N(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .din(din16), .in_desc(ds16),
    .out_valid(ov16), .out_ready(or16), .dout(do16)
`ifdef BITONIC_MERGER_SWAP_CNT_EN
    , .swap_cnt(sc16)
`endif
  );

  function automatic int elem(logic [127:0] v, int i, int w);
    logic [127:0] mask;
    mask = (128'd1 << w) - 128'd1;
    return int'((v >> (i * w)) & mask);
  endfunction

  // Bitonic = ascending run then descending run, rotated by a random amount.
  function automatic logic [127:0] gen_bitonic(int n, int w);
    int a[16];
    int p, r, t;
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < n; i++) a[i] = int'($urandom_range(0, (1 << w) - 1));
    p = int'($urandom_range(0, n - 1));
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n - 1 - i; j++) begin
        if ((j + 1 <= p && a[j] > a[j+1]) || (j > p && a[j] < a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
      end
    end
    r = int'($urandom_range(0, n - 1));
    for (int i = 0; i < n; i++) v = v | (128'(a[i]) << (((i + r) % n) * w));
    return v;
  endfunction

  function automatic logic [127:0] ref_sort(logic [127:0] v, int n, int w, bit desc);
    int a[16];
    int t;
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < n; i++) a[i] = elem(v, i, w);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n - 1 - i; j++) begin
        if (desc ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
      end
    end
    for (int i = 0; i < n; i++) r = r | (128'(a[i]) << (i * w));
    return r;
  endfunction

  // Explicit half-cleaner cascade, used where the input need not be bitonic.
  task automatic ref_net(input logic [127:0] v, input int n, input int w, input bit desc,
                         output logic [127:0] r, output int cnt);
    int a[16];
    int b, h, t;
    r = '0;
    cnt = 0;
    for (int i = 0; i < n; i++) a[i] = elem(v, i, w);
    for (int s = 0; (n >> s) >= 2; s++) begin
      b = n >> s;
      h = b / 2;
      for (int j = 0; j < n; j += b) begin
        for (int i = 0; i < h; i++) begin
          if (desc ? (a[j+i] < a[j+i+h]) : (a[j+i] > a[j+i+h])) begin
            t = a[j+i]; a[j+i] = a[j+i+h]; a[j+i+h] = t;
            cnt++;
          end
        end
      end
    end
    for (int i = 0; i < n; i++) r = r | (128'(a[i]) << (i * w));
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (ov4 !== 1'b0 || ov8 !== 1'b0 || ov16 !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b%b%b want 000", ov4, ov8, ov16);
    end
    checks++;
    if (do4 !== 16'h0) begin errors++; $display("FAIL reset_dout got %h want 0000", do4); end
    checks++;
    if (ir4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ir4); end
`ifdef BITONIC_MERGER_SWAP_CNT_EN
    checks++;
    if (sc4 !== 3'd0) begin errors++; $display("FAIL reset_swap_cnt got %0d want 0", sc4); end
`endif
  endtask

  task automatic test_single_vector(input string name, input logic [15:0] v, input bit desc,
                                    input logic [15:0] exp, input int exp_sw);
    iv4 = 1'b1; din4 = v; ds4 = desc;
    checks++;
    if (ir4 !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %b want 1", name, ir4); end
    @(posedge clk); #1;
    iv4 = 1'b0;
    checks++;
    if (ov4 !== 1'b0) begin errors++; $display("FAIL %s_early got out_valid %b want 0", name, ov4); end
    @(posedge clk); #1;
    checks++;
    if (ov4 !== 1'b1 || do4 !== exp) begin
      errors++; $display("FAIL %s_result got v=%b dout=%h want v=1 dout=%h", name, ov4, do4, exp);
    end
`ifdef BITONIC_MERGER_SWAP_CNT_EN
    checks++;
    if (int'(sc4) != exp_sw) begin errors++; $display("FAIL %s_swap_cnt got %0d want %0d", name, sc4, exp_sw); end
`else
    if (exp_sw < 0) $display("note: negative swap count argument ignored");
`endif
    @(posedge clk); #1;
    checks++;
    if (ov4 !== 1'b0) begin errors++; $display("FAIL %s_pulse got out_valid %b want 0", name, ov4); end
  endtask

  // Arbitrary (not necessarily bitonic) vectors, desc alternating every cycle.
  task automatic test_back_to_back();
    logic [127:0] vin[8];
    logic [127:0] vexp[8];
    int sw[8];
    for (int k = 0; k < 8; k++) begin
      vin[k] = {112'b0, 16'($urandom)};
      ref_net(vin[k], 4, 4, (k % 2) == 1, vexp[k], sw[k]);
    end
    for (int c = 0; c < 12; c++) begin
      iv4 = (c < 8); din4 = vin[c % 8][15:0]; ds4 = (c % 2) == 1;
      @(posedge clk); #1;
      checks++;
      if (c >= 1 && c <= 8) begin
        if (ov4 !== 1'b1 || do4 !== vexp[c-1][15:0]) begin
          errors++; $display("FAIL b2b_vec%0d got v=%b dout=%h want v=1 dout=%h", c - 1, ov4, do4, vexp[c-1][15:0]);
        end
`ifdef BITONIC_MERGER_SWAP_CNT_EN
        else if (int'(sc4) != sw[c-1]) begin
          errors++; $display("FAIL b2b_swap%0d got %0d want %0d", c - 1, sc4, sw[c-1]);
        end
`endif
      end else if (ov4 !== 1'b0) begin
        errors++; $display("FAIL b2b_idle%0d got out_valid %b want 0", c, ov4);
      end
    end
    iv4 = 1'b0;
  endtask

  task automatic test_stall();
    logic [127:0] v[3];
    logic [127:0] e[3];
    int sw;
    for (int k = 0; k < 3; k++) begin
      v[k] = gen_bitonic(4, 4);
      ref_net(v[k], 4, 4, 1'b0, e[k], sw);
    end
    or4 = 1'b0; iv4 = 1'b1; ds4 = 1'b0; din4 = v[0][15:0];
    @(posedge clk); #1;
    din4 = v[1][15:0];
    @(posedge clk); #1;
    din4 = v[2][15:0];
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (ir4 !== 1'b0 || ov4 !== 1'b1 || do4 !== e[0][15:0]) begin
        errors++; $display("FAIL stall_hold%0d got rdy=%b v=%b dout=%h want rdy=0 v=1 dout=%h", c, ir4, ov4, do4, e[0][15:0]);
      end
      @(posedge clk); #1;
    end
    or4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    checks++;
    if (ov4 !== 1'b1 || do4 !== e[1][15:0]) begin
      errors++; $display("FAIL stall_rel1 got v=%b dout=%h want v=1 dout=%h", ov4, do4, e[1][15:0]);
    end
    @(posedge clk); #1;
    checks++;
    if (ov4 !== 1'b1 || do4 !== e[2][15:0]) begin
      errors++; $display("FAIL stall_rel2 got v=%b dout=%h want v=1 dout=%h", ov4, do4, e[2][15:0]);
    end
    @(posedge clk); #1;
    checks++;
    if (ov4 !== 1'b0) begin errors++; $display("FAIL stall_drain got out_valid %b want 0", ov4); end
  endtask

  task automatic test_reset_midflight();
    iv4 = 1'b1; ds4 = 1'b1; din4 = 16'h3751;
    @(posedge clk); #1;
    din4 = 16'h8421;
    @(posedge clk); #1;
    iv4 = 1'b0;
    checks++;
    if (ov4 !== 1'b1) begin errors++; $display("FAIL midrst_inflight got out_valid %b want 1", ov4); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (ov4 !== 1'b0 || do4 !== 16'h0 || ir4 !== 1'b1) begin
      errors++; $display("FAIL midrst_clear got v=%b dout=%h rdy=%b want v=0 dout=0000 rdy=1", ov4, do4, ir4);
    end
`ifdef BITONIC_MERGER_SWAP_CNT_EN
    checks++;
    if (sc4 !== 3'd0) begin errors++; $display("FAIL midrst_swap_cnt got %0d want 0", sc4); end
`endif
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (ov4 !== 1'b0) begin errors++; $display("FAIL midrst_stale%0d got out_valid %b want 0", c, ov4); end
    end
  endtask

  task automatic test_random(input int n, input int nvec);
    logic [127:0] q[$];
    int qs[$];
    logic [127:0] cur, exp, dv, net_r;
    bit cur_desc, iv, ir, ov, orr;
    int sent, cyc, sw, got_sw, exp_sw;
    sent = 0; cyc = 0; got_sw = 0;
    cur = gen_bitonic(n, 8);
    cur_desc = 1'($urandom_range(0, 1));
    while ((sent < nvec || q.size() != 0) && cyc < 4000) begin
      iv = (sent < nvec) && ($urandom_range(0, 9) < 7);
      orr = ($urandom_range(0, 9) < 7);
      if (n == 8) begin
        iv8 = iv; din8 = cur[63:0]; ds8 = cur_desc; or8 = orr;
      end else begin
        iv16 = iv; din16 = cur; ds16 = cur_desc; or16 = orr;
      end
      #1;
      if (n == 8) begin
        ir = ir8; ov = ov8; dv = {64'b0, do8};
`ifdef BITONIC_MERGER_SWAP_CNT_EN
        got_sw = int'(sc8);
`endif
      end else begin
        ir = ir16; ov = ov16; dv = do16;
`ifdef BITONIC_MERGER_SWAP_CNT_EN
        got_sw = int'(sc16);
`endif
      end
      if (ov && orr) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand%0d_unexpected got dout=%h want no output", n, dv);
        end else begin
          exp = q.pop_front();
          exp_sw = qs.pop_front();
          if (dv !== exp) begin
            errors++; $display("FAIL rand%0d_data got %h want %h", n, dv, exp);
          end
`ifdef BITONIC_MERGER_SWAP_CNT_EN
          checks++;
          if (got_sw != exp_sw) begin
            errors++; $display("FAIL rand%0d_swap_cnt got %0d want %0d", n, got_sw, exp_sw);
          end
`endif
        end
      end
      if (iv && ir) begin
        ref_net(cur, n, 8, cur_desc, net_r, sw);
        q.push_back(ref_sort(cur, n, 8, cur_desc));
        qs.push_back(sw);
        sent++;
        cur = gen_bitonic(n, 8);
        cur_desc = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    iv8 = 1'b0; or8 = 1'b1; iv16 = 1'b0; or16 = 1'b1;
    checks++;
    if (sent < nvec || q.size() != 0) begin
      errors++; $display("FAIL rand%0d_timeout got sent=%0d pending=%0d want sent=%0d pending=0", n, sent, q.size(), nvec);
    end
  endtask

  initial begin
    iv4 = 1'b0; din4 = '0; ds4 = 1'b0; or4 = 1'b1;
    iv8 = 1'b0; din8 = '0; ds8 = 1'b0; or8 = 1'b1;
    iv16 = 1'b0; din16 = '0; ds16 = 1'b0; or16 = 1'b1;
    test_reset();
    test_single_vector("asc", 16'h3751, 1'b0, 16'h7531, 2);
    test_single_vector("desc", 16'h3751, 1'b1, 16'h1357, 2);
    test_single_vector("equal", 16'h5555, 1'b0, 16'h5555, 0);
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random(8, 200);
    test_random(16, 200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
